// File: rtl/iterative_divider.sv
// rtl/iterative_divider.sv - multi-cycle restoring divider (signed/unsigned) for UDIV/SDIV
//
// Purpose: computes quotient and remainder of two WIDTH-bit operands with one
// shift/trial-subtract step per clock. Signed operands are divided as
// magnitudes and sign-corrected in a final FIX cycle (truncating division:
// the remainder takes the sign of the dividend). Fixed latency of WIDTH+1
// cycles from the accepting edge to the done pulse.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   start        request, sampled only while ready=1
//   is_signed    1 = two's-complement divide, 0 = unsigned (captured with start)
//   dividend     numerator (captured with start)
//   divisor      denominator (captured with start)
//   ready        idle and able to accept start
//   done         one-cycle pulse, results valid from this cycle onward
//   quotient     registered quotient, held until the next completion
//   remainder    registered remainder, held until the next completion
//   div_by_zero  last completed operation had a zero divisor

module iterative_divider #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]    cnt_q, cnt_d;
    // Dividend register; quotient bits shift in at the LSB as dividend bits leave the MSB.
    logic [WIDTH-1:0] dvd_q, dvd_d;
    // Partial remainder carries one extra bit so the trial subtract never
    // overflows when the unsigned divisor has its MSB set.
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] orig_q, orig_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic             a_neg;
    logic             b_neg;

    assign shifted = {rem_q, dvd_q[WIDTH-1]};
    // Top bit of diff is the borrow: set when the trial subtract went negative.
    assign diff    = shifted - {2'b00, dvs_q};
    assign a_neg   = is_signed & dividend[WIDTH-1];
    assign b_neg   = is_signed & divisor[WIDTH-1];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (cnt_q == '0) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready = (state_q == S_IDLE);
    end

    // Datapath next-state
    always_comb begin
        cnt_d  = cnt_q;
        dvd_d  = dvd_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        orig_d = orig_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        zero_d = zero_q;
        quo_d  = quo_q;
        remo_d = remo_q;
        dbz_d  = dbz_q;
        done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d  = CW'(WIDTH - 1);
                    dvd_d  = a_neg ? -dividend : dividend;
                    dvs_d  = b_neg ? -divisor : divisor;
                    rem_d  = '0;
                    orig_d = dividend;
                    qneg_d = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    zero_d = (divisor == '0);
                end
            end
            S_RUN: begin
                dvd_d = {dvd_q[WIDTH-2:0], ~diff[WIDTH+1]};
                rem_d = diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0];
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_FIX: begin
                // Most-negative / -1 falls out naturally: magnitude 2^(WIDTH-1) negates to itself.
                quo_d  = zero_q ? '0 : (qneg_q ? -dvd_q : dvd_q);
                remo_d = zero_q ? orig_q
                                : (rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0]);
                dbz_d  = zero_q;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            dvd_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            orig_q <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            zero_q <= 1'b0;
            quo_q  <= '0;
            remo_q <= '0;
            dbz_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dvd_q  <= dvd_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            orig_q <= orig_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            zero_q <= zero_d;
            quo_q  <= quo_d;
            remo_q <= remo_d;
            dbz_q  <= dbz_d;
            done_q <= done_d;
        end
    end

    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iterative_divider.sv
// tb/tb_iterative_divider.sv - scoreboard bench for iterative_divider

module tb_iterative_divider;

    localparam int W = 64;
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ALL_ONE = {W{1'b1}};

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         ready;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    iterative_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
        start     = 1'b1;
        is_signed = sg;
        dividend  = a;
        divisor   = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic launch(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
        exp_t e;
        e.q   = eq;
        e.r   = er;
        e.dbz = edbz;
        sb.push_back(e);
        drive(sg, a, b);
    endtask

    // Returns at the negedge of the done cycle so a caller may launch back-to-back.
    task automatic wait_result(input string tag, input int skipped);
        bit   seen;
        exp_t e;
        seen = 1'b0;
        for (int k = skipped + 1; k <= W + 8 && !seen; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                check({tag, " latency"}, k, W + 1);
                check({tag, " ready@done"}, ready, 1);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL %s scoreboard: observed=done expected=no pending op", tag);
                end else begin
                    e = sb.pop_front();
                    check({tag, " quotient"}, quotient, e.q);
                    check({tag, " remainder"}, remainder, e.r);
                    check({tag, " div_by_zero"}, div_by_zero, e.dbz);
                end
            end else if (k <= W) begin
                check({tag, " ready busy"}, ready, 0);
            end
        end
        if (!seen) check({tag, " timeout done"}, done, 1);
    endtask

    initial begin : stim
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           dcount;

        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #2;
        check("reset ready", ready, 1);
        check("reset done", done, 0);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset dbz", div_by_zero, 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // 1: unsigned 100 / 7
        launch(1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0);
        wait_result("t1", 0);
        @(negedge clk);
        check("t1 done single", done, 0);

        // 2: signed combinations, chained in the done cycle
        launch(1'b1, -64'd100, 64'd7, -64'd14, -64'd2, 1'b0);
        wait_result("t2a", 0);
        launch(1'b1, 64'd100, -64'd7, -64'd14, 64'd2, 1'b0);
        wait_result("t2b", 0);
        launch(1'b1, -64'd100, -64'd7, 64'd14, -64'd2, 1'b0);
        wait_result("t2c", 0);

        // 3: unsigned divisor with MSB set, signed overflow
        launch(1'b0, ALL_ONE, MIN_NEG, 64'd1, ALL_ONE >> 1, 1'b0);
        wait_result("t3a", 0);
        launch(1'b1, MIN_NEG, ALL_ONE, MIN_NEG, 64'd0, 1'b0);
        wait_result("t3b", 0);

        // 4: divide by zero, signed then unsigned
        launch(1'b1, -64'd5, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1);
        wait_result("t4s", 0);
        launch(1'b0, -64'd5, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1);
        wait_result("t4u", 0);

        // Random operands against a behavioural model
        for (int i = 0; i < 4; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom} >> $urandom_range(0, 62);
            if (b == '0) b = 64'd3;
            if (i[0]) begin
                launch(1'b1, a, b, W'($signed(a) / $signed(b)), W'($signed(a) % $signed(b)), 1'b0);
            end else begin
                launch(1'b0, a, b, a / b, a % b, 1'b0);
            end
            wait_result("rand", 0);
        end

        // 5: start while busy is ignored; clears the earlier div_by_zero
        @(negedge clk);
        launch(1'b0, 64'd1000, 64'd9, 64'd111, 64'd1, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        start     = 1'b1;
        is_signed = 1'b1;
        dividend  = 64'd50;
        divisor   = 64'd5;
        @(posedge clk);
        #1 start = 1'b0;
        wait_result("t5", 10);
        @(negedge clk);
        check("t5 done single", done, 0);
        dcount = 0;
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("t5 no extra done", dcount, 0);
        check("t5 hold quotient", quotient, 64'd111);

        // 6: asynchronous reset in the middle of RUN
        drive(1'b0, 64'd1234, 64'd5);
        repeat (20) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("t6 ready", ready, 1);
        check("t6 done", done, 0);
        check("t6 quotient", quotient, 0);
        check("t6 remainder", remainder, 0);
        check("t6 dbz", div_by_zero, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        dcount = 0;
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("t6 no done", dcount, 0);
        launch(1'b0, 64'd9, 64'd3, 64'd3, 64'd0, 1'b0);
        wait_result("t6 9/3", 0);

        check("sb drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
